// File: rtl/game_ctrl.sv
// game_ctrl: crossing-game sequencer owning screen state, player position, lives and score.
// Build option: define GAME_CTRL_GOD_MODE_EN to disable collisions (game ends only by win).
`timescale 1ns/1ps

module game_ctrl_axis #(
    parameter int W    = 10,
    parameter int MIN  = 15,
    parameter int MAX  = 624,
    parameter int STEP = 5
) (
    input  logic [W-1:0] pos,
    input  logic         dec,
    input  logic         inc,
    output logic [W-1:0] nxt
);
    localparam logic [10:0]  DEC_LIM = 11'(MIN + STEP);
    localparam logic [10:0]  INC_LIM = 11'(MAX - STEP);
    localparam logic [W-1:0] LO_W    = W'(MIN);
    localparam logic [W-1:0] HI_W    = W'(MAX);
    localparam logic [W-1:0] ST_W    = W'(STEP);

    logic [10:0] p;

    // Limits are checked in 11 bits so a step can never wrap the W-bit result.
    always_comb begin
        p   = 11'(pos);
        nxt = pos;
        if (dec)
            nxt = (p < DEC_LIM) ? LO_W : pos - ST_W;
        else if (inc)
            nxt = (p > INC_LIM) ? HI_W : pos + ST_W;
    end
endmodule

module game_ctrl #(
    parameter int STEP         = 5,
    parameter int START_H      = 320,
    parameter int START_V      = 450,
    parameter int H_MIN        = 15,
    parameter int H_MAX        = 624,
    parameter int V_MIN        = 50,
    parameter int V_MAX        = 464,
    parameter int GOAL_V       = 65,
    parameter int WIN_CROSS    = 5,
    parameter int FLASH_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       collide,
    output logic [1:0] state,
    output logic [9:0] player_h,
    output logic [8:0] player_v,
    output logic       l1,
    output logic       l2,
    output logic       l3,
    output logic [2:0] score,
    output logic       win
);
    localparam logic [1:0] S_TITLE = 2'b00;
    localparam logic [1:0] S_PLAY  = 2'b01;
    localparam logic [1:0] S_HIT   = 2'b10;
    localparam logic [1:0] S_OVER  = 2'b11;

    localparam int            FW         = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [9:0]    H0         = 10'(START_H);
    localparam logic [8:0]    V0         = 9'(START_V);
    localparam logic [10:0]   GOAL       = 11'(GOAL_V);
    localparam logic [2:0]    WIN_SC     = 3'(WIN_CROSS);

    logic          btn_start_q;
    logic          start_re;
    logic          col_g;
    logic [FW-1:0] flash_cnt;
    logic [9:0]    h_nxt;
    logic [8:0]    v_nxt;
    logic [2:0]    score_inc;
    logic          goal;

`ifdef GAME_CTRL_GOD_MODE_EN
    // Collisions masked: lives never drop and HIT is never entered.
    assign col_g = collide & 1'b0;
`else
    assign col_g = collide;
`endif

    assign start_re  = btn_start & ~btn_start_q;
    assign score_inc = score + 3'd1;
    assign goal      = (11'(v_nxt) <= GOAL);

    game_ctrl_axis #(.W(10), .MIN(H_MIN), .MAX(H_MAX), .STEP(STEP)) u_axis_h (
        .pos (player_h),
        .dec (btn_left),
        .inc (btn_right),
        .nxt (h_nxt)
    );

    game_ctrl_axis #(.W(9), .MIN(V_MIN), .MAX(V_MAX), .STEP(STEP)) u_axis_v (
        .pos (player_v),
        .dec (btn_up),
        .inc (btn_down),
        .nxt (v_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_TITLE;
            player_h    <= H0;
            player_v    <= V0;
            l1          <= 1'b1;
            l2          <= 1'b1;
            l3          <= 1'b1;
            score       <= 3'd0;
            win         <= 1'b0;
            flash_cnt   <= '0;
            btn_start_q <= 1'b0;
        end else begin
            btn_start_q <= btn_start;
            case (state)
                S_TITLE: begin
                    if (start_re) begin
                        state    <= S_PLAY;
                        l1       <= 1'b1;
                        l2       <= 1'b1;
                        l3       <= 1'b1;
                        score    <= 3'd0;
                        win      <= 1'b0;
                        player_h <= H0;
                        player_v <= V0;
                    end
                end
                S_PLAY: begin
                    // A collision pre-empts any move or goal check in the same cycle.
                    if (col_g) begin
                        state     <= S_HIT;
                        flash_cnt <= '0;
                        player_h  <= H0;
                        player_v  <= V0;
                        if (l3)      l3 <= 1'b0;
                        else if (l2) l2 <= 1'b0;
                        else         l1 <= 1'b0;
                    end else if (frame_tick) begin
                        if (goal) begin
                            score    <= score_inc;
                            player_h <= H0;
                            player_v <= V0;
                            if (score_inc == WIN_SC) begin
                                win   <= 1'b1;
                                state <= S_OVER;
                            end
                        end else begin
                            player_h <= h_nxt;
                            player_v <= v_nxt;
                        end
                    end
                end
                S_HIT: begin
                    if (frame_tick) begin
                        if (flash_cnt == FLASH_LAST)
                            state <= (l1 | l2 | l3) ? S_PLAY : S_OVER;
                        else
                            flash_cnt <= flash_cnt + 1'b1;
                    end
                end
                default: begin
                    if (start_re) begin
                        state    <= S_TITLE;
                        player_h <= H0;
                        player_v <= V0;
                    end
                end
            endcase
        end
    end
endmodule
